// File: rtl/fc_ip_seq.sv
// fc_ip_seq: sequencer for the fully-connected inner-product datapath.
// For each output neuron it fetches the bias word from the weight stream,
// then streams inn (activation, weight) pairs into the multiply-adder, and
// finally emits the neuron-done strobe. The strobe is spaced so that the
// datapath's accumulator read is never overlapped by the next bias load.

module fc_ip_seq #(
  parameter int FW = 32,  // data / weight word width
  parameter int NW = 13,  // width of neuron counts
  parameter int AW = 12   // activation-buffer address width
) (
  input  logic          clk_i,
  input  logic          rstn_i,

  // layer control
  input  logic          start_i,
  input  logic [NW-1:0] inn_i,
  input  logic [NW-1:0] onn_i,

  // weight stream (bias word first, then inn weights, per neuron)
  input  logic [FW-1:0] w_data_i,
  input  logic          w_valid_i,
  output logic          w_ready_o,

  // activation buffer read port (1-cycle read latency)
  output logic          data_rd_o,
  output logic [AW-1:0] data_addr_o,
  input  logic [FW-1:0] data_i,

  // to the ip_mul_add datapath
  output logic [FW-1:0] ip_data_o,
  output logic          ip_data_valid_o,
  output logic [FW-1:0] ip_weight_o,
  output logic          ip_weight_valid_o,
  output logic [FW-1:0] ip_bias_o,
  output logic          ip_bias_valid_o,
  output logic          ip_oneuron_done_o,

  // layer status
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [NW-1:0] CNT_ONE = NW'(1);

  typedef enum logic [2:0] {
    S_IDLE,   // waiting for a layer start
    S_BIAS,   // fetching the bias word of the current neuron
    S_MAC,    // streaming inn (data, weight) pairs
    S_DRAIN,  // last pair is in flight to the datapath
    S_DONE    // neuron-done strobe; accumulator is read next cycle
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched layer geometry and loop counters
  logic [NW-1:0] inn_q;
  logic [NW-1:0] onn_q;
  logic [NW-1:0] in_cnt;
  logic [NW-1:0] on_cnt;

  // Datapath-facing registers
  logic [FW-1:0] bias_q;
  logic          bias_valid_q;
  logic [FW-1:0] weight_q;
  logic          mac_valid_q;

  // Status registers
  logic          busy_q;
  logic          done_q;

  // Decoded conditions shared by the processes below
  logic start_ok;
  logic zero_layer;
  logic bias_hs;
  logic mac_hs;
  logic last_in;
  logic last_on;

  assign start_ok   = (state == S_IDLE) && start_i;
  assign zero_layer = (inn_i == '0) || (onn_i == '0);
  assign bias_hs    = (state == S_BIAS) && w_valid_i;
  assign mac_hs     = (state == S_MAC) && w_valid_i;
  assign last_in    = (in_cnt == (inn_q - CNT_ONE));
  assign last_on    = ((on_cnt + CNT_ONE) == onn_q);

  // State register
  // NOTE: every clocked process uses non-blocking (<=) assignments so that all
  // registers sample pre-edge values; blocking here would create order races.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_i && !zero_layer) state_nxt = S_BIAS;
      S_BIAS:  if (w_valid_i) state_nxt = S_MAC;
      S_MAC:   if (w_valid_i && last_in) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = last_on ? S_IDLE : S_BIAS;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs: stream ready, buffer read and neuron strobe
  always_comb begin
    w_ready_o         = 1'b0;
    data_rd_o         = 1'b0;
    ip_oneuron_done_o = 1'b0;
    unique case (state)
      S_BIAS:  w_ready_o = 1'b1;
      S_MAC: begin
        w_ready_o = 1'b1;
        data_rd_o = w_valid_i;
      end
      S_DONE:  ip_oneuron_done_o = 1'b1;
      default: ;
    endcase
  end

  // The address is the input counter itself; it restarts at 0 for each neuron
  assign data_addr_o = in_cnt[AW-1:0];

  // Layer geometry capture and input / neuron counters
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      inn_q  <= '0;
      onn_q  <= '0;
      in_cnt <= '0;
      on_cnt <= '0;
    end else begin
      if (start_ok) begin
        inn_q  <= inn_i;
        onn_q  <= onn_i;
        in_cnt <= '0;
        on_cnt <= '0;
      end else if (mac_hs && !last_in) begin
        // Hold on the last pair so the counter never exceeds inn-1
        in_cnt <= in_cnt + CNT_ONE;
      end else if (state == S_DONE) begin
        in_cnt <= '0;
        on_cnt <= on_cnt + CNT_ONE;
      end
    end
  end

  // Datapath registers: bias and weight words plus their one-cycle valids
  // NOTE: the word registers are reset along with the valids because the
  // datapath buses must read 0 while reset is asserted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bias_q       <= '0;
      bias_valid_q <= 1'b0;
      weight_q     <= '0;
      mac_valid_q  <= 1'b0;
    end else begin
      bias_valid_q <= bias_hs;
      mac_valid_q  <= mac_hs;
      if (bias_hs) bias_q   <= w_data_i;
      if (mac_hs)  weight_q <= w_data_i;
    end
  end

  // Activation data arrives one cycle after the read, aligned with the
  // registered weight; it is masked so the bus is quiet between pairs.
  assign ip_data_o         = mac_valid_q ? data_i : '0;
  assign ip_data_valid_o   = mac_valid_q;
  assign ip_weight_o       = weight_q;
  assign ip_weight_valid_o = mac_valid_q;
  assign ip_bias_o         = bias_q;
  assign ip_bias_valid_o   = bias_valid_q;

  // Layer status: busy from the cycle after start, done pulse at layer end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (start_ok && zero_layer) || ((state == S_DONE) && last_on);
      if (start_ok && !zero_layer) begin
        busy_q <= 1'b1;
      end else if ((state == S_DONE) && last_on) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
